// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, fetch FSM encodings and the NOP word for the fetch stage.
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush or bubble loads a NOP marked invalid, load captures a real instruction.
//   clk, rst           clock, synchronous active-high reset
//   i_load             capture i_instr/i_pc4 as a valid instruction
//   i_bubble, i_flush  capture NOP with i_pc4 as an invalid slot (flush wins over load)
//   o_instr/o_pc4/o_valid  register contents
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_pc4,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_pc4,
    output logic              o_valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_instr <= NOP_INSTR;
            o_pc4   <= '0;
            o_valid <= 1'b0;
        end else if (i_flush || i_bubble) begin
            o_instr <= NOP_INSTR;
            o_pc4   <= i_pc4;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_pc4   <= i_pc4;
            o_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM with hold buffer, and IF/ID register.
//   Inputs : clk, rst, PC_wr_en, IF_ID_wr_en, flush_flag, redirect_target, imem_ready, imem_rvalid, imem_rdata
//   Outputs: imem_req, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, IF_miss
//   FETCH_PERF_EN adds perf_fetch_cnt, perf_bubble_cnt, perf_squash_cnt (saturating).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_wr_en,
    input  logic              IF_ID_wr_en,
    input  logic              flush_flag,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] IF_ID_instr,
    output logic [WORD_W-1:0] IF_ID_pc4,
    output logic              IF_ID_valid,
    output logic              IF_miss
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_W-1:0] perf_fetch_cnt,
    output logic [WORD_W-1:0] perf_bubble_cnt,
    output logic [WORD_W-1:0] perf_squash_cnt
`endif
);
    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_hold;
    logic              r_squash;
    logic [1:0]        w_state_nxt;
    logic              w_squash_nxt;
    logic              w_adv;
    logic              w_resp;
    logic              w_drop;
    logic              w_deliver;
    logic              w_bubble;
    logic [WORD_W-1:0] w_instr;
    logic [WORD_W-1:0] w_pc4;
    always_comb begin
        w_adv     = PC_wr_en && IF_ID_wr_en;
        w_resp    = (r_state == ST_WAIT) && imem_rvalid;
        // a response for a request issued before a redirect is never delivered
        w_drop    = w_resp && (r_squash || flush_flag);
        w_deliver = !flush_flag && w_adv && ((w_resp && !r_squash) || (r_state == ST_HOLD));
        w_bubble  = IF_ID_wr_en && !w_deliver;
        w_instr   = (r_state == ST_HOLD) ? r_hold : imem_rdata;
        w_pc4     = pc_plus4(r_pc);
        w_state_nxt =
            (r_state == ST_ISSUE) ? (imem_ready ? ST_WAIT : ST_ISSUE) :
            (r_state == ST_WAIT)  ? (imem_rvalid ? ((w_drop || w_adv) ? ST_ISSUE : ST_HOLD) : ST_WAIT) :
            (r_state == ST_HOLD)  ? ((flush_flag || w_adv) ? ST_ISSUE : ST_HOLD) : ST_ISSUE;
        // squash marks an in-flight request whose address was overtaken by a redirect
        w_squash_nxt =
            (r_state == ST_ISSUE) ? (flush_flag && imem_ready) :
            (r_state == ST_WAIT)  ? (!imem_rvalid && (r_squash || flush_flag)) : 1'b0;
    end
    assign imem_req  = !rst && (r_state == ST_ISSUE);
    assign imem_addr = r_pc;
    assign IF_miss   = w_bubble;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ISSUE;
            r_pc     <= RESET_PC;
            r_squash <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_squash <= w_squash_nxt;
            r_pc     <= flush_flag ? (redirect_target & 32'hFFFF_FFFC) : w_deliver ? w_pc4 : r_pc;
            if (w_resp) r_hold <= imem_rdata;
        end
    end
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_deliver),
        .i_bubble (w_bubble),
        .i_flush  (flush_flag),
        .i_instr  (w_instr),
        .i_pc4    (w_pc4),
        .o_instr  (IF_ID_instr),
        .o_pc4    (IF_ID_pc4),
        .o_valid  (IF_ID_valid)
    );
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (w_deliver && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((flush_flag || w_bubble) && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (w_drop && perf_squash_cnt != '1) perf_squash_cnt <= perf_squash_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a tiny imem whose word is addr ^ 32'hDEAD_0000.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_wr_en = 1'b1;
    logic        IF_ID_wr_en = 1'b1;
    logic        flush_flag = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic        IF_miss;
    logic [31:0] last_addr = '0;
    int          vectors = 0;
    int          miscompares = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .PC_wr_en        (PC_wr_en),
        .IF_ID_wr_en     (IF_ID_wr_en),
        .flush_flag      (flush_flag),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_pc4       (IF_ID_pc4),
        .IF_ID_valid     (IF_ID_valid),
        .IF_miss         (IF_miss)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req && imem_ready) last_addr <= imem_addr;
    assign imem_rdata = last_addr ^ 32'hDEAD_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b exp 0", IF_ID_valid); end
        vectors++; if (IF_ID_instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h exp 00000000", IF_ID_instr); end
        vectors++; if (IF_ID_pc4 !== 32'h0) begin miscompares++; $display("FAIL rst_pc4 got %h exp 00000000", IF_ID_pc4); end
        rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL issue_req got %0b exp 1", imem_req); end
        vectors++; if (IF_miss !== 1'b1) begin miscompares++; $display("FAIL issue_miss got %0b exp 1", IF_miss); end
    endtask

    task automatic test_stream();
        imem_ready = 1'b1;
        imem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL stream_bubble_valid[%0d] got %0b exp 0", k, IF_ID_valid); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stream_wait_req[%0d] got %0b exp 0", k, imem_req); end
            tick();
            vectors++; if (IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %0b exp 1", k, IF_ID_valid); end
            vectors++; if (IF_ID_pc4 !== 32'(4 * (k + 1))) begin miscompares++; $display("FAIL stream_pc4[%0d] got %h exp %h", k, IF_ID_pc4, 32'(4 * (k + 1))); end
            vectors++; if (IF_ID_instr !== (32'hDEAD_0000 | 32'(4 * k))) begin miscompares++; $display("FAIL stream_instr[%0d] got %h exp %h", k, IF_ID_instr, 32'hDEAD_0000 | 32'(4 * k)); end
            vectors++; if (imem_addr !== 32'(4 * (k + 1))) begin miscompares++; $display("FAIL stream_addr[%0d] got %h exp %h", k, imem_addr, 32'(4 * (k + 1))); end
        end
    endtask

    task automatic test_stall();
        PC_wr_en = 1'b0;
        IF_ID_wr_en = 1'b0;
        imem_ready = 1'b1;
        imem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            imem_ready = 1'b0;
            imem_rvalid = (k == 0);
            vectors++; if (IF_ID_pc4 !== 32'd16 || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold[%0d] got pc4=%h v=%0b exp pc4=00000010 v=1", k, IF_ID_pc4, IF_ID_valid); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d] got %0b exp 0", k, imem_req); end
        end
        vectors++; if (IF_miss !== 1'b0) begin miscompares++; $display("FAIL stall_miss got %0b exp 0", IF_miss); end
        PC_wr_en = 1'b1;
        IF_ID_wr_en = 1'b1;
        tick();
        vectors++; if (IF_ID_instr !== 32'hDEAD_0010 || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL release_instr got %h v=%0b exp DEAD0010 v=1", IF_ID_instr, IF_ID_valid); end
        vectors++; if (IF_ID_pc4 !== 32'd20) begin miscompares++; $display("FAIL release_pc4 got %h exp 00000014", IF_ID_pc4); end
        vectors++; if (imem_addr !== 32'd20 || imem_req !== 1'b1) begin miscompares++; $display("FAIL release_addr got %h req=%0b exp 00000014 req=1", imem_addr, imem_req); end
    endtask

    task automatic test_flush_wait();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        flush_flag = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        flush_flag = 1'b0;
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL fw_valid got %0b exp 0", IF_ID_valid); end
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL fw_addr got %h exp 00000100", imem_addr); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL fw_req got %0b exp 0", imem_req); end
        tick();
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL fw_drop_valid got %0b exp 0", IF_ID_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL fw_reissue got req=%0b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (IF_ID_instr !== 32'hDEAD_0100 || IF_ID_pc4 !== 32'h104 || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL fw_target got %h/%h/%0b exp DEAD0100/00000104/1", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
    endtask

    task automatic test_flush_issue();
        flush_flag = 1'b1;
        redirect_target = 32'h0000_0200;
        imem_ready = 1'b1;
        tick();
        flush_flag = 1'b0;
        imem_ready = 1'b0;
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL fi_wait got req=%0b addr=%h exp req=0 addr=00000200", imem_req, imem_addr); end
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL fi_valid got %0b exp 0", IF_ID_valid); end
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (IF_ID_valid !== 1'b0) begin miscompares++; $display("FAIL fi_squash_valid got %0b exp 0", IF_ID_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL fi_reissue got req=%0b addr=%h exp req=1 addr=00000200", imem_req, imem_addr); end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (IF_ID_instr !== 32'hDEAD_0200 || IF_ID_pc4 !== 32'h204 || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL fi_target got %h/%h/%0b exp DEAD0200/00000204/1", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
    endtask

    task automatic test_wrap();
        flush_flag = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        flush_flag = 1'b0;
        vectors++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_align got addr=%h req=%0b exp FFFFFFFC req=1", imem_addr, imem_req); end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vectors++; if (IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_pc4 got %h v=%0b exp 00000000 v=1", IF_ID_pc4, IF_ID_valid); end
        vectors++; if (IF_ID_instr !== 32'h2152_FFFC) begin miscompares++; $display("FAIL wrap_instr got %h exp 2152FFFC", IF_ID_instr); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_in_wait got %0b exp 0", imem_req); end
        rst = 1'b1;
        tick();
        vectors++; if (IF_ID_valid !== 1'b0 || IF_ID_pc4 !== 32'h0 || IF_ID_instr !== 32'h0) begin miscompares++; $display("FAIL rw_ifid got %h/%h/%0b exp 00000000/00000000/0", IF_ID_instr, IF_ID_pc4, IF_ID_valid); end
        vectors++; if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_pc got addr=%h req=%0b exp 00000000 req=0", imem_addr, imem_req); end
        rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rw_issue got %0b exp 1", imem_req); end
`ifdef FETCH_PERF_EN
        vectors++; if ({perf_fetch_cnt, perf_bubble_cnt, perf_squash_cnt} !== 96'h0) begin miscompares++; $display("FAIL rw_perf got %h/%h/%h exp 0/0/0", perf_fetch_cnt, perf_bubble_cnt, perf_squash_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_wait();
        test_flush_issue();
        test_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
